// File: rtl/pipe_stage_chain_if.sv
// Valid/ready bundle carrying a control field and a payload.
// master drives the item, slave answers with ready.
interface pipe_stage_chain_if #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
);
  logic              valid;
  logic              ready;
  logic [CTRL_W-1:0] ctrl;
  logic [DATA_W-1:0] data;

  modport master (
    output valid,
    output ctrl,
    output data,
    input  ready
  );

  modport slave (
    input  valid,
    input  ctrl,
    input  data,
    output ready
  );
endinterface

// File: rtl/pipe_stage_chain.sv
// Elastic chain of DEPTH pipeline registers with stall, flush,
// valid/ready backpressure and bubble collapsing.
module pipe_stage_chain #(
  parameter  int DATA_W = 32,
  parameter  int CTRL_W = 8,
  parameter  int DEPTH  = 2,
  localparam int OCC_W  = $clog2(DEPTH + 1)
) (
  input  logic               CLK,
  input  logic               RST_N,
  input  logic               EN,
  input  logic               CLR,
  pipe_stage_chain_if.slave  in_if,
  pipe_stage_chain_if.master out_if,
  output logic [OCC_W-1:0]   OCCUPANCY
);

  if (DEPTH < 1 || DEPTH > 8) begin : g_bad_depth
    $error("pipe_stage_chain: DEPTH must be 1..8");
  end

  logic [DEPTH-1:0]  v_q;
  logic [DEPTH-1:0]  v_d;
  logic [DEPTH-1:0]  rdy;
  logic [CTRL_W-1:0] ctrl_q [DEPTH];
  logic [CTRL_W-1:0] ctrl_d [DEPTH];
  logic [DATA_W-1:0] data_q [DEPTH];
  logic [DATA_W-1:0] data_d [DEPTH];

  logic             rdy_acc;
  logic             in_ready;
  logic             in_xfer;
  logic [OCC_W-1:0] occ;

  // A stage is ready if it is empty or anything below it can move.
  always_comb begin
    rdy     = '0;
    rdy_acc = out_if.ready;
    for (int i = DEPTH - 1; i >= 0; i--) begin
      rdy_acc = ~v_q[i] | rdy_acc;
      rdy[i]  = rdy_acc;
    end
  end

  always_comb begin
    in_ready = RST_N & EN & ~CLR & rdy[0];
    in_xfer  = in_if.valid & in_ready;
  end

  assign in_if.ready = in_ready;

  always_comb begin
    v_d    = v_q;
    ctrl_d = ctrl_q;
    data_d = data_q;
    if (CLR) begin
      v_d = '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_d[i] = '0;
      end
    end else if (EN) begin
      if (rdy[0]) begin
        v_d[0] = in_xfer;
        if (in_xfer) begin
          ctrl_d[0] = in_if.ctrl;
          data_d[0] = in_if.data;
        end else begin
          ctrl_d[0] = '0;
        end
      end
      for (int i = 1; i < DEPTH; i++) begin
        if (rdy[i]) begin
          v_d[i] = v_q[i-1];
          if (v_q[i-1]) begin
            ctrl_d[i] = ctrl_q[i-1];
            data_d[i] = data_q[i-1];
          end else begin
            ctrl_d[i] = '0;
          end
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      v_q <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        ctrl_q[i] <= '0;
        data_q[i] <= '0;
      end
    end else begin
      v_q    <= v_d;
      ctrl_q <= ctrl_d;
      data_q <= data_d;
    end
  end

  always_comb begin
    occ = '0;
    for (int i = 0; i < DEPTH; i++) begin
      occ = occ + OCC_W'(v_q[i]);
    end
  end

  assign OCCUPANCY   = occ;
  assign out_if.valid = v_q[DEPTH-1] & EN & ~CLR;
  assign out_if.ctrl  = ctrl_q[DEPTH-1];
  assign out_if.data  = data_q[DEPTH-1];

endmodule

// File: tb/tb_pipe_stage_chain.sv
// Directed bench: DEPTH=3 chain driven from a vector table,
// plus a DEPTH=1 instance and an asynchronous reset sequence.
module tb_pipe_stage_chain;

  logic       CLK = 1'b0;
  logic       RST_N;
  logic       EN;
  logic       CLR;
  logic [1:0] occ_a;
  logic [0:0] occ_b;

  int n_tests = 0;
  int n_fail  = 0;

  pipe_stage_chain_if #(.DATA_W(32), .CTRL_W(4)) a_in ();
  pipe_stage_chain_if #(.DATA_W(32), .CTRL_W(4)) a_out ();
  pipe_stage_chain_if #(.DATA_W(32), .CTRL_W(4)) b_in ();
  pipe_stage_chain_if #(.DATA_W(32), .CTRL_W(4)) b_out ();

  pipe_stage_chain #(.DATA_W(32), .CTRL_W(4), .DEPTH(3)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN        (EN),
    .CLR       (CLR),
    .in_if     (a_in),
    .out_if    (a_out),
    .OCCUPANCY (occ_a)
  );

  pipe_stage_chain #(.DATA_W(32), .CTRL_W(4), .DEPTH(1)) dut1 (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .EN        (EN),
    .CLR       (CLR),
    .in_if     (b_in),
    .out_if    (b_out),
    .OCCUPANCY (occ_b)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic        en;
    logic        clr;
    logic        iv;
    logic        ordy;
    logic [3:0]  ic;
    logic [31:0] id;
    logic        x_ir;
    logic [1:0]  x_occ;
    logic        x_ov;
    logic [3:0]  x_oc;
    logic [31:0] x_od;
  } vec_t;

  localparam int NV = 29;
  vec_t tv [NV];

  function automatic vec_t mk(
    logic en, logic clr, logic iv, logic ordy,
    logic [3:0] ic, logic [31:0] id,
    logic ir, logic [1:0] occ, logic ov,
    logic [3:0] oc, logic [31:0] od
  );
    vec_t r;
    r.en = en; r.clr = clr; r.iv = iv; r.ordy = ordy;
    r.ic = ic; r.id = id;
    r.x_ir = ir; r.x_occ = occ; r.x_ov = ov;
    r.x_oc = oc; r.x_od = od;
    return r;
  endfunction

  task automatic chk(string nm, logic [63:0] act, logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  initial begin
    // streaming
    tv[0]  = mk(1,0,1,1,4'hF,32'h10, 1,2'd1,0,4'h0,32'h0);
    tv[1]  = mk(1,0,1,1,4'hF,32'h11, 1,2'd2,0,4'h0,32'h0);
    tv[2]  = mk(1,0,1,1,4'hF,32'h12, 1,2'd3,1,4'hF,32'h10);
    tv[3]  = mk(1,0,1,1,4'hF,32'h13, 1,2'd3,1,4'hF,32'h11);
    tv[4]  = mk(1,0,0,1,4'h0,32'h0,  1,2'd2,1,4'hF,32'h12);
    tv[5]  = mk(1,0,0,1,4'h0,32'h0,  1,2'd1,1,4'hF,32'h13);
    tv[6]  = mk(1,0,0,1,4'h0,32'h0,  1,2'd0,0,4'h0,32'h13);
    // backpressure and collapse
    tv[7]  = mk(1,0,1,0,4'h5,32'hA0, 1,2'd1,0,4'h0,32'h13);
    tv[8]  = mk(1,0,1,0,4'h5,32'hA1, 1,2'd2,0,4'h0,32'h13);
    tv[9]  = mk(1,0,1,0,4'h5,32'hA2, 1,2'd3,1,4'h5,32'hA0);
    tv[10] = mk(1,0,1,0,4'h5,32'hA3, 0,2'd3,1,4'h5,32'hA0);
    tv[11] = mk(1,0,1,1,4'h5,32'hA3, 1,2'd3,1,4'h5,32'hA1);
    tv[12] = mk(1,0,0,1,4'h0,32'h0,  1,2'd2,1,4'h5,32'hA2);
    tv[13] = mk(1,0,0,1,4'h0,32'h0,  1,2'd1,1,4'h5,32'hA3);
    tv[14] = mk(1,0,0,1,4'h0,32'h0,  1,2'd0,0,4'h0,32'hA3);
    // stall with two items held
    tv[15] = mk(1,0,1,1,4'h3,32'hB0, 1,2'd1,0,4'h0,32'hA3);
    tv[16] = mk(1,0,1,1,4'h3,32'hB1, 1,2'd2,0,4'h0,32'hA3);
    tv[17] = mk(0,0,1,1,4'h3,32'hB2, 0,2'd2,0,4'h0,32'hA3);
    tv[18] = mk(0,0,1,1,4'h3,32'hB2, 0,2'd2,0,4'h0,32'hA3);
    tv[19] = mk(0,0,1,1,4'h3,32'hB2, 0,2'd2,0,4'h0,32'hA3);
    tv[20] = mk(0,0,1,1,4'h3,32'hB2, 0,2'd2,0,4'h0,32'hA3);
    tv[21] = mk(1,0,0,1,4'h0,32'h0,  1,2'd2,1,4'h3,32'hB0);
    tv[22] = mk(1,0,0,1,4'h0,32'h0,  1,2'd1,1,4'h3,32'hB1);
    tv[23] = mk(1,0,0,1,4'h0,32'h0,  1,2'd0,0,4'h0,32'hB1);
    // flush beats stall
    tv[24] = mk(1,0,1,0,4'hF,32'hC0, 1,2'd1,0,4'h0,32'hB1);
    tv[25] = mk(1,0,1,0,4'hF,32'hC1, 1,2'd2,0,4'h0,32'hB1);
    tv[26] = mk(1,0,1,0,4'hF,32'hC2, 1,2'd3,1,4'hF,32'hC0);
    tv[27] = mk(0,1,1,0,4'hF,32'hC3, 0,2'd0,0,4'h0,32'hC0);
    tv[28] = mk(1,0,0,1,4'h0,32'h0,  1,2'd0,0,4'h0,32'hC0);

    RST_N = 1'b0;
    EN    = 1'b1;
    CLR   = 1'b0;
    a_in.valid = 1'b0; a_in.ctrl = '0; a_in.data = '0;
    a_out.ready = 1'b1;
    b_in.valid = 1'b0; b_in.ctrl = '0; b_in.data = '0;
    b_out.ready = 1'b0;

    #12;
    chk("rst.in_ready", 64'(a_in.ready), 64'd0);
    chk("rst.out_valid", 64'(a_out.valid), 64'd0);
    chk("rst.out_ctrl", 64'(a_out.ctrl), 64'd0);
    chk("rst.out_data", 64'(a_out.data), 64'd0);
    chk("rst.occ", 64'(occ_a), 64'd0);
    chk("rst.d1_occ", 64'(occ_b), 64'd0);
    RST_N = 1'b1;
    tick();

    for (int i = 0; i < NV; i++) begin
      EN          = tv[i].en;
      CLR         = tv[i].clr;
      a_in.valid  = tv[i].iv;
      a_in.ctrl   = tv[i].ic;
      a_in.data   = tv[i].id;
      a_out.ready = tv[i].ordy;
      #1;
      chk($sformatf("v%0d.in_ready", i), 64'(a_in.ready), 64'(tv[i].x_ir));
      tick();
      chk($sformatf("v%0d.occ", i), 64'(occ_a), 64'(tv[i].x_occ));
      chk($sformatf("v%0d.out_valid", i), 64'(a_out.valid), 64'(tv[i].x_ov));
      chk($sformatf("v%0d.out_ctrl", i), 64'(a_out.ctrl), 64'(tv[i].x_oc));
      chk($sformatf("v%0d.out_data", i), 64'(a_out.data), 64'(tv[i].x_od));
    end

    a_in.valid = 1'b0;
    EN = 1'b1;
    CLR = 1'b0;

    // DEPTH=1: fill, hold under backpressure, then replace every cycle
    b_in.valid = 1'b1; b_in.ctrl = 4'h1; b_in.data = 32'hD0;
    b_out.ready = 1'b0;
    #1;
    chk("d1.in_ready_empty", 64'(b_in.ready), 64'd1);
    tick();
    chk("d1.occ_fill", 64'(occ_b), 64'd1);
    chk("d1.valid_fill", 64'(b_out.valid), 64'd1);
    chk("d1.data_fill", 64'(b_out.data), 64'hD0);
    b_in.data = 32'hD9;
    #1;
    chk("d1.in_ready_full", 64'(b_in.ready), 64'd0);
    tick();
    chk("d1.data_held", 64'(b_out.data), 64'hD0);
    b_out.ready = 1'b1;
    for (int k = 1; k <= 3; k++) begin
      b_in.data = 32'hD0 + 32'(k);
      #1;
      chk($sformatf("d1.in_ready_%0d", k), 64'(b_in.ready), 64'd1);
      tick();
      chk($sformatf("d1.occ_%0d", k), 64'(occ_b), 64'd1);
      chk($sformatf("d1.data_%0d", k), 64'(b_out.data), 64'hD0 + 64'(k));
      chk($sformatf("d1.ctrl_%0d", k), 64'(b_out.ctrl), 64'h1);
    end
    b_in.valid = 1'b0; b_in.ctrl = 'x; b_in.data = 'x;
    tick();
    chk("d1.occ_drain", 64'(occ_b), 64'd0);
    chk("d1.valid_drain", 64'(b_out.valid), 64'd0);
    chk("d1.ctrl_no_x", 64'(b_out.ctrl), 64'd0);
    chk("d1.data_kept", 64'(b_out.data), 64'hD3);
    b_in.ctrl = '0; b_in.data = '0;
    b_out.ready = 1'b0;

    // async reset with items in flight, asserted between edges
    a_out.ready = 1'b1;
    a_in.valid = 1'b1; a_in.ctrl = 4'h7; a_in.data = 32'hE0;
    tick();
    a_in.data = 32'hE1;
    tick();
    a_in.data = 32'hE2;
    tick();
    chk("ar.occ_before", 64'(occ_a), 64'd3);
    chk("ar.valid_before", 64'(a_out.valid), 64'd1);
    #2;
    RST_N = 1'b0;
    #1;
    chk("ar.out_valid", 64'(a_out.valid), 64'd0);
    chk("ar.out_ctrl", 64'(a_out.ctrl), 64'd0);
    chk("ar.out_data", 64'(a_out.data), 64'd0);
    chk("ar.occ", 64'(occ_a), 64'd0);
    chk("ar.in_ready", 64'(a_in.ready), 64'd0);
    a_in.valid = 1'b0;
    tick();
    RST_N = 1'b1;
    tick();
    chk("ar.occ_release", 64'(occ_a), 64'd0);
    tick();
    chk("ar.no_replay", 64'(a_out.valid), 64'd0);
    chk("ar.occ_after", 64'(occ_a), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
